// File: rtl/comp_corr_tracker.sv
// Per-antenna (re+im)/(re-im) component accumulator with double-buffered storage
// and a random-access baseline correction read port.
module comp_corr_tracker #(
  parameter int BITWIDTH         = 4,
  parameter int P_FACTOR_BITS    = 2,
  parameter int N_POLS           = 2,
  parameter int N_ANTS           = 32,
  parameter int ACC_LEN_BITS_MAX = 10,
  localparam int P      = 1 << P_FACTOR_BITS,
  localparam int SUM_W  = BITWIDTH + P_FACTOR_BITS,
  localparam int PM_W   = SUM_W + 2,
  localparam int ACC_W  = PM_W + ACC_LEN_BITS_MAX,
  localparam int CORR_W = ACC_W + 1,
  localparam int ANT_W  = (N_ANTS > 1) ? $clog2(N_ANTS) : 1,
  localparam int LEN_W  = $clog2(ACC_LEN_BITS_MAX + 1),
  localparam int DIN_W  = N_POLS * P * BITWIDTH,
  localparam int OUT_W  = N_POLS * N_POLS * CORR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [LEN_W-1:0]  acc_len_bits,
  input  logic              din_vld,
  input  logic [DIN_W-1:0]  din_re,
  input  logic [DIN_W-1:0]  din_im,
  input  logic              rd_en,
  input  logic [ANT_W-1:0]  rd_ant_a,
  input  logic [ANT_W-1:0]  rd_ant_b,
  input  logic              rd_done,
  output logic              rd_vld,
  output logic [OUT_W-1:0]  re_corr,
  output logic [OUT_W-1:0]  im_corr,
  output logic              buf_done,
  output logic              overrun,
  output logic              dbg_state
);

  localparam int AW    = ANT_W + 1;
  localparam int DEPTH = 1 << AW;
  localparam int ENT_W = N_POLS * 2 * ACC_W;
  localparam int VW    = ACC_LEN_BITS_MAX;
  localparam int VW1   = ACC_LEN_BITS_MAX + 1;

  // Handshake: din is consumed on every cycle din_vld is high while in ACC (or
  // with sync); rd_en is a request with no back-pressure, answered by rd_vld
  // exactly three cycles later.
  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ANT_W-1:0] ant_q, ant_d, ant_cur;
  logic [VW-1:0]    vec_q, vec_d, vec_cur;
  logic [LEN_W-1:0] len_q, len_d, len_clamp, len_eff;
  logic             in_buf_q, in_buf_d;
  logic             act_buf_q, act_buf_d;
  logic             held_q, held_d;
  logic             overrun_q, overrun_d;
  logic             buf_done_q, buf_done_d;
  logic             accept, last_ant, last_vec, commit_last;

  logic                    s1_vld_q, s1_vld_d, s1_buf_q, s1_buf_d;
  logic                    s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [ANT_W-1:0]        s1_ant_q, s1_ant_d;
  logic [SUM_W-1:0]        s1_s_q [N_POLS];
  logic [SUM_W-1:0]        s1_s_d [N_POLS];
  logic signed [SUM_W-1:0] s1_t_q [N_POLS];
  logic signed [SUM_W-1:0] s1_t_d [N_POLS];
  logic [SUM_W-1:0]        s_acc;
  logic signed [SUM_W-1:0] t_acc;
  logic [BITWIDTH-1:0]     re_smp;
  logic signed [BITWIDTH-1:0] im_smp;

  logic                    s2_vld_q, s2_vld_d, s2_buf_q, s2_buf_d;
  logic                    s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic [ANT_W-1:0]        s2_ant_q, s2_ant_d;
  logic signed [PM_W-1:0]  s2_p_q [N_POLS];
  logic signed [PM_W-1:0]  s2_p_d [N_POLS];
  logic signed [PM_W-1:0]  s2_m_q [N_POLS];
  logic signed [PM_W-1:0]  s2_m_d [N_POLS];

  logic [ENT_W-1:0]        mem [DEPTH];
  logic [ENT_W-1:0]        acc_old_q, acc_old_d, wr_data;
  logic [AW-1:0]           s1_addr, wr_addr;
  logic                    wr_en;
  logic signed [ACC_W-1:0] old_p, old_m;

  logic                    r1_vld_q, r1_vld_d, r2_vld_q, r2_vld_d;
  logic [AW-1:0]           r1_a_q, r1_a_d, r1_b_q, r1_b_d;
  logic [ENT_W-1:0]        rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [OUT_W-1:0]        re_corr_q, re_corr_d, im_corr_q, im_corr_d;
  logic signed [ACC_W-1:0] pa_v, pb_v, ma_v, mb_v;

  // Input side: counters, FSM, per-pol sums.
  always_comb begin
    len_clamp = (acc_len_bits > LEN_W'(ACC_LEN_BITS_MAX)) ? LEN_W'(ACC_LEN_BITS_MAX) : acc_len_bits;
    len_eff   = sync ? len_clamp : len_q;
    ant_cur   = sync ? '0 : ant_q;
    vec_cur   = sync ? '0 : vec_q;
    accept    = din_vld && (sync || (state_q == ST_ACC));
    last_ant  = (ant_cur == ANT_W'(N_ANTS - 1));
    last_vec  = (({1'b0, vec_cur} + VW1'(1)) == (VW1'(1) << len_eff));
    state_d   = sync ? ST_ACC : state_q;
    len_d     = len_eff;
    ant_d     = ant_cur;
    vec_d     = vec_cur;
    in_buf_d  = in_buf_q;
    if (accept) begin
      if (last_ant) begin
        ant_d = '0;
        vec_d = last_vec ? '0 : vec_cur + VW'(1);
        if (last_vec) in_buf_d = ~in_buf_q;
      end else begin
        ant_d = ant_cur + ANT_W'(1);
      end
    end
    s1_vld_d   = accept;
    s1_ant_d   = ant_cur;
    s1_buf_d   = in_buf_q;
    s1_first_d = (vec_cur == '0);
    s1_last_d  = last_ant && last_vec;
    s_acc  = '0;
    t_acc  = '0;
    re_smp = '0;
    im_smp = '0;
    for (int k = 0; k < N_POLS; k++) begin
      s_acc = '0;
      t_acc = '0;
      for (int i = 0; i < P; i++) begin
        re_smp = din_re[(k*P+i)*BITWIDTH +: BITWIDTH];
        im_smp = din_im[(k*P+i)*BITWIDTH +: BITWIDTH];
        s_acc  = s_acc + SUM_W'(re_smp);
        t_acc  = t_acc + SUM_W'(im_smp);
      end
      s1_s_d[k] = s_acc;
      s1_t_d[k] = t_acc;
    end
  end

  // p/m stage; the accumulator read for this sample is issued in parallel.
  always_comb begin
    s2_vld_d   = s1_vld_q;
    s2_ant_d   = s1_ant_q;
    s2_buf_d   = s1_buf_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    for (int k = 0; k < N_POLS; k++) begin
      s2_p_d[k] = $signed({2'b00, s1_s_q[k]}) + PM_W'(s1_t_q[k]);
      s2_m_d[k] = $signed({2'b00, s1_s_q[k]}) - PM_W'(s1_t_q[k]);
    end
    s1_addr = {s1_buf_q, s1_ant_q};
  end

  // Commit stage: first vector overwrites, later vectors add.
  always_comb begin
    wr_en   = s2_vld_q;
    wr_addr = {s2_buf_q, s2_ant_q};
    wr_data = '0;
    old_p   = '0;
    old_m   = '0;
    for (int k = 0; k < N_POLS; k++) begin
      old_p = s2_first_q ? '0 : $signed(acc_old_q[(2*k)*ACC_W +: ACC_W]);
      old_m = s2_first_q ? '0 : $signed(acc_old_q[(2*k+1)*ACC_W +: ACC_W]);
      wr_data[(2*k)*ACC_W +: ACC_W]   = old_p + ACC_W'(s2_p_q[k]);
      wr_data[(2*k+1)*ACC_W +: ACC_W] = old_m + ACC_W'(s2_m_q[k]);
    end
    // A commit landing on the address being fetched is forwarded.
    acc_old_d   = (wr_en && (wr_addr == s1_addr)) ? wr_data : mem[s1_addr];
    commit_last = s2_vld_q && s2_last_q;
    act_buf_d   = commit_last ? ~act_buf_q : act_buf_q;
    buf_done_d  = commit_last;
    held_d      = commit_last ? 1'b1 : (rd_done ? 1'b0 : held_q);
    overrun_d   = overrun_q | (commit_last && held_q && !rd_done);
  end

  // Read side: sample the completed buffer at rd_en, fetch, then combine.
  always_comb begin
    r1_vld_d  = rd_en;
    r1_a_d    = {~act_buf_q, rd_ant_a};
    r1_b_d    = {~act_buf_q, rd_ant_b};
    r2_vld_d  = r1_vld_q;
    rd_a_d    = mem[r1_a_q];
    rd_b_d    = mem[r1_b_q];
    rd_vld_d  = r2_vld_q;
    re_corr_d = re_corr_q;
    im_corr_d = im_corr_q;
    pa_v = '0;
    pb_v = '0;
    ma_v = '0;
    mb_v = '0;
    if (r2_vld_q) begin
      for (int pa = 0; pa < N_POLS; pa++) begin
        for (int pb = 0; pb < N_POLS; pb++) begin
          pa_v = $signed(rd_a_q[(2*pa)*ACC_W +: ACC_W]);
          ma_v = $signed(rd_a_q[(2*pa+1)*ACC_W +: ACC_W]);
          pb_v = $signed(rd_b_q[(2*pb)*ACC_W +: ACC_W]);
          mb_v = $signed(rd_b_q[(2*pb+1)*ACC_W +: ACC_W]);
          re_corr_d[(pa*N_POLS+pb)*CORR_W +: CORR_W] = CORR_W'(pa_v) + CORR_W'(pb_v);
          im_corr_d[(pa*N_POLS+pb)*CORR_W +: CORR_W] = CORR_W'(mb_v) - CORR_W'(ma_v);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    acc_old_q <= acc_old_d;
    rd_a_q    <= rd_a_d;
    rd_b_q    <= rd_b_d;
    s1_ant_q  <= s1_ant_d;
    s1_buf_q  <= s1_buf_d;
    s1_first_q <= s1_first_d;
    s1_last_q <= s1_last_d;
    s2_ant_q  <= s2_ant_d;
    s2_buf_q  <= s2_buf_d;
    s2_first_q <= s2_first_d;
    s2_last_q <= s2_last_d;
    r1_a_q    <= r1_a_d;
    r1_b_q    <= r1_b_d;
    for (int k = 0; k < N_POLS; k++) begin
      s1_s_q[k] <= s1_s_d[k];
      s1_t_q[k] <= s1_t_d[k];
      s2_p_q[k] <= s2_p_d[k];
      s2_m_q[k] <= s2_m_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ant_q      <= '0;
      vec_q      <= '0;
      len_q      <= '0;
      in_buf_q   <= 1'b0;
      act_buf_q  <= 1'b0;
      held_q     <= 1'b0;
      overrun_q  <= 1'b0;
      buf_done_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      r1_vld_q   <= 1'b0;
      r2_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      re_corr_q  <= '0;
      im_corr_q  <= '0;
    end else begin
      state_q    <= state_d;
      ant_q      <= ant_d;
      vec_q      <= vec_d;
      len_q      <= len_d;
      in_buf_q   <= in_buf_d;
      act_buf_q  <= act_buf_d;
      held_q     <= held_d;
      overrun_q  <= overrun_d;
      buf_done_q <= buf_done_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      r1_vld_q   <= r1_vld_d;
      r2_vld_q   <= r2_vld_d;
      rd_vld_q   <= rd_vld_d;
      re_corr_q  <= re_corr_d;
      im_corr_q  <= im_corr_d;
    end
  end

  assign rd_vld    = rd_vld_q;
  assign re_corr   = re_corr_q;
  assign im_corr   = im_corr_q;
  assign buf_done  = buf_done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_comp_corr_tracker.sv
// Directed bench for comp_corr_tracker: N_ANTS=4, P=2, BITWIDTH=4, N_POLS=2.
module tb_comp_corr_tracker;

  localparam int CW  = 18;
  localparam int OW  = 4 * CW;

  logic          clk = 1'b0;
  logic          rst, sync, din_vld, rd_en, rd_done;
  logic [3:0]    acc_len_bits;
  logic [15:0]   din_re, din_im;
  logic [1:0]    rd_ant_a, rd_ant_b;
  logic          rd_vld, buf_done, overrun, dbg_state;
  logic [OW-1:0] re_corr, im_corr;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_im_q[$];
  logic [OW-1:0] exp_re, exp_im;

  comp_corr_tracker #(
    .BITWIDTH(4), .P_FACTOR_BITS(1), .N_POLS(2), .N_ANTS(4), .ACC_LEN_BITS_MAX(10)
  ) dut (
    .clk(clk), .rst(rst), .sync(sync), .acc_len_bits(acc_len_bits),
    .din_vld(din_vld), .din_re(din_re), .din_im(din_im),
    .rd_en(rd_en), .rd_ant_a(rd_ant_a), .rd_ant_b(rd_ant_b), .rd_done(rd_done),
    .rd_vld(rd_vld), .re_corr(re_corr), .im_corr(im_corr),
    .buf_done(buf_done), .overrun(overrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] rep4(input int v);
    logic [CW-1:0] x;
    x = CW'(v);
    return {x, x, x, x};
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one sample for the cycle ending at the next posedge.
  task automatic drive_sample(input logic [3:0] re, input logic [3:0] im, input logic sy);
    din_vld = 1'b1;
    sync    = sy;
    din_re  = {4{re}};
    din_im  = {4{im}};
    @(negedge clk);
    din_vld = 1'b0;
    sync    = 1'b0;
  endtask

  // Returns at the negedge where the response to this request is presented.
  task automatic do_read(input logic [1:0] a, input logic [1:0] b);
    rd_en = 1'b1;
    rd_ant_a = a;
    rd_ant_b = b;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    reset_dut();
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL reset_rd_vld: got %b expected 0", rd_vld); end
    checks++; if (re_corr !== '0) begin failures++; $display("FAIL reset_re_corr: got %h expected 0", re_corr); end
    checks++; if (im_corr !== '0) begin failures++; $display("FAIL reset_im_corr: got %h expected 0", im_corr); end
    checks++; if (buf_done !== 1'b0) begin failures++; $display("FAIL reset_buf_done: got %b expected 0", buf_done); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    // IDLE ignores din: a full buffer's worth of samples must not complete anything.
    for (int i = 0; i < 8; i++) drive_sample(4'd9, 4'd2, 1'b0);
    seen = 1'b0;
    repeat (5) begin
      if (buf_done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL idle_ignore: got buf_done=1 expected 0"); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL idle_state: got %b expected 0", dbg_state); end
  endtask

  task automatic test_constant();
    for (int i = 0; i < 8; i++) drive_sample(4'd9, 4'd2, i == 0);
    checks++; if (dbg_state !== 1'b1) begin failures++; $display("FAIL const_state: got %b expected 1", dbg_state); end
    checks++; if (buf_done !== 1'b0) begin failures++; $display("FAIL const_done_early1: got %b expected 0", buf_done); end
    @(negedge clk);
    checks++; if (buf_done !== 1'b0) begin failures++; $display("FAIL const_done_early2: got %b expected 0", buf_done); end
    @(negedge clk);
    checks++; if (buf_done !== 1'b1) begin failures++; $display("FAIL const_done: got %b expected 1", buf_done); end
    @(negedge clk);
    checks++; if (buf_done !== 1'b0) begin failures++; $display("FAIL const_done_pulse: got %b expected 0", buf_done); end
    do_read(2'd0, 2'd2);
    checks++; if (rd_vld !== 1'b1) begin failures++; $display("FAIL const_rd_vld: got %b expected 1", rd_vld); end
    checks++; if (re_corr !== rep4(88)) begin failures++; $display("FAIL const_re: got %h expected %h", re_corr, rep4(88)); end
    checks++; if (im_corr !== rep4(0)) begin failures++; $display("FAIL const_im: got %h expected %h", im_corr, rep4(0)); end
    @(negedge clk);
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL const_rd_vld_drop: got %b expected 0", rd_vld); end
    pulse_rd_done();
  endtask

  task automatic test_len0();
    acc_len_bits = 4'd0;
    for (int i = 0; i < 4; i++) drive_sample(4'd9, 4'd2, i == 0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (buf_done !== 1'b1) begin failures++; $display("FAIL len0_done: got %b expected 1", buf_done); end
    do_read(2'd0, 2'd1);
    checks++; if (re_corr !== rep4(44)) begin failures++; $display("FAIL len0_re: got %h expected %h", re_corr, rep4(44)); end
    checks++; if (im_corr !== rep4(0)) begin failures++; $display("FAIL len0_im: got %h expected %h", im_corr, rep4(0)); end
    pulse_rd_done();
    acc_len_bits = 4'd1;
  endtask

  task automatic test_antenna();
    for (int i = 0; i < 8; i++) drive_sample(4'd8, 4'(i % 4), i == 0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (buf_done !== 1'b1) begin failures++; $display("FAIL ant_done: got %b expected 1", buf_done); end
    do_read(2'd1, 2'd3);
    checks++; if (re_corr !== rep4(80)) begin failures++; $display("FAIL ant_re_13: got %h expected %h", re_corr, rep4(80)); end
    checks++; if (im_corr !== rep4(-8)) begin failures++; $display("FAIL ant_im_13: got %h expected %h", im_corr, rep4(-8)); end
    do_read(2'd0, 2'd0);
    checks++; if (re_corr !== rep4(64)) begin failures++; $display("FAIL ant_re_00: got %h expected %h", re_corr, rep4(64)); end
    checks++; if (im_corr !== rep4(0)) begin failures++; $display("FAIL ant_im_00: got %h expected %h", im_corr, rep4(0)); end
    pulse_rd_done();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) drive_sample(4'd9, 4'd2, i == 0);
    repeat (3) @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_first: got %b expected 0", overrun); end
    for (int i = 0; i < 8; i++) drive_sample(4'd9, 4'd2, 1'b0);
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before: got %b expected 0", overrun); end
    @(negedge clk);
    checks++; if (buf_done !== 1'b1 || overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_second: got done=%b overrun=%b expected 1 1", buf_done, overrun);
    end
    repeat (3) @(negedge clk);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    // Release coinciding with the swap must not count as an overrun.
    reset_dut();
    for (int i = 0; i < 8; i++) drive_sample(4'd9, 4'd2, i == 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_sample(4'd9, 4'd2, 1'b0);
    @(negedge clk);
    rd_done = 1'b1;
    @(negedge clk);
    checks++; if (buf_done !== 1'b1 || overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_release_swap: got done=%b overrun=%b expected 1 0", buf_done, overrun);
    end
    @(negedge clk);
    rd_done = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_release_after: got %b expected 0", overrun); end
    do_read(2'd3, 2'd1);
    checks++; if (re_corr !== rep4(88)) begin failures++; $display("FAIL ovr_re: got %h expected %h", re_corr, rep4(88)); end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 5; i++) drive_sample(4'd15, 4'd7, i == 0);
    for (int i = 0; i < 8; i++) drive_sample(4'd9, 4'd2, i == 0);
    checks++; if (buf_done !== 1'b0) begin failures++; $display("FAIL rst_done_early: got %b expected 0", buf_done); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (buf_done !== 1'b1) begin failures++; $display("FAIL restart_done: got %b expected 1", buf_done); end
    do_read(2'd2, 2'd3);
    checks++; if (re_corr !== rep4(88)) begin failures++; $display("FAIL restart_re: got %h expected %h", re_corr, rep4(88)); end
    checks++; if (im_corr !== rep4(0)) begin failures++; $display("FAIL restart_im: got %h expected %h", im_corr, rep4(0)); end
    pulse_rd_done();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 8; i++) begin
      drive_sample(4'd8, 4'(i % 4), i == 0);
      if (i == 1 || i == 4 || i == 5) @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (buf_done !== 1'b1) begin failures++; $display("FAIL gaps_done: got %b expected 1", buf_done); end
    do_read(2'd1, 2'd3);
    checks++; if (re_corr !== rep4(80)) begin failures++; $display("FAIL gaps_re: got %h expected %h", re_corr, rep4(80)); end
    checks++; if (im_corr !== rep4(-8)) begin failures++; $display("FAIL gaps_im: got %h expected %h", im_corr, rep4(-8)); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] aa [3];
    logic [1:0] bb [3];
    aa = '{2'd1, 2'd3, 2'd0};
    bb = '{2'd3, 2'd1, 2'd2};
    exp_q.push_back(rep4(80));    exp_im_q.push_back(rep4(-8));
    exp_q.push_back(rep4(80));    exp_im_q.push_back(rep4(8));
    exp_q.push_back(rep4(72));    exp_im_q.push_back(rep4(-8));
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 3) begin
        rd_en = 1'b1; rd_ant_a = aa[cyc]; rd_ant_b = bb[cyc];
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 2 && cyc < 5) begin
        exp_re = exp_q.pop_front();
        exp_im = exp_im_q.pop_front();
        checks++; if (rd_vld !== 1'b1 || re_corr !== exp_re || im_corr !== exp_im) begin
          failures++;
          $display("FAIL b2b_%0d: got vld=%b re=%h im=%h expected 1 %h %h", cyc - 2, rd_vld, re_corr, im_corr, exp_re, exp_im);
        end
      end else if (cyc == 5) begin
        checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b expected 0", rd_vld); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    rd_en = 1'b1; rd_ant_a = 2'd1; rd_ant_b = 2'd3;
    @(negedge clk);
    rd_en = 1'b0;
    rst = 1'b1;
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL rmr_n1: got %b expected 0", rd_vld); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL rmr_n2: got %b expected 0", rd_vld); end
    @(negedge clk);
    checks++; if (rd_vld !== 1'b0 || re_corr !== '0 || im_corr !== '0) begin
      failures++; $display("FAIL rmr_n3: got vld=%b re=%h im=%h expected 0 0 0", rd_vld, re_corr, im_corr);
    end
    checks++; if (buf_done !== 1'b0 || overrun !== 1'b0 || dbg_state !== 1'b0) begin
      failures++; $display("FAIL rmr_ctrl: got done=%b ovr=%b st=%b expected 0 0 0", buf_done, overrun, dbg_state);
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; din_vld = 1'b0; din_re = '0; din_im = '0;
    rd_en = 1'b0; rd_ant_a = '0; rd_ant_b = '0; rd_done = 1'b0; acc_len_bits = 4'd1;
    @(negedge clk);
    test_reset();
    test_constant();
    test_len0();
    test_antenna();
    test_overrun();
    test_restart();
    test_gaps();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
